// File: rtl/mmio_slot_router.sv
// Data-side router: sends core loads/stores to block RAM or to one of NUM_SLOTS
// req/ack peripheral slots on the MMIO page, with per-access timeout and error log.
module mmio_slot_router #(
  parameter int          DATA_W     = 32,
  parameter int          RAM_AW     = 11,
  parameter logic [19:0] MMIO_PAGE  = 20'hAAAAA,
  parameter int          NUM_SLOTS  = 4,
  parameter int          SLOT_SHIFT = 8,
  parameter int          TIMEOUT    = 15
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [31:0]                 cpu_addr,
  input  logic [DATA_W-1:0]           cpu_wdata,
  input  logic [DATA_W/8-1:0]         cpu_be,
  input  logic                        cpu_we,
  input  logic                        cpu_re,
  output logic [DATA_W-1:0]           cpu_rdata,
  output logic                        cpu_stall,
  output logic                        cpu_err,
  output logic                        ram_en,
  output logic [DATA_W/8-1:0]         ram_we,
  output logic [RAM_AW-1:0]           ram_addr,
  output logic [DATA_W-1:0]           ram_wdata,
  input  logic [DATA_W-1:0]           ram_rdata,
  output logic [NUM_SLOTS-1:0]        slv_req,
  output logic                        slv_we,
  output logic [SLOT_SHIFT-1:0]       slv_addr,
  output logic [DATA_W-1:0]           slv_wdata,
  output logic [DATA_W/8-1:0]         slv_be,
  input  logic [NUM_SLOTS*DATA_W-1:0] slv_rdata,
  input  logic [NUM_SLOTS-1:0]        slv_ack,
  output logic [7:0]                  err_count,
  output logic [31:0]                 err_addr
);

  localparam int          IDX_W       = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam logic [11:0] NUM_SLOTS_L = 12'(NUM_SLOTS);
  localparam logic [7:0]  CNT_LAST    = 8'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_RAM_RD   = 2'd1;
  localparam logic [1:0] S_SLV_WAIT = 2'd2;
  localparam logic [1:0] S_RESP     = 2'd3;

  logic [1:0]        state;
  logic [IDX_W-1:0]  idx;
  logic [7:0]        cnt;
  logic [DATA_W-1:0] rsp;
  logic              rsp_err;

  logic              cpu_req;
  logic              is_ram;
  logic              is_slot;
  logic [11:0]       slot_num;
  logic [IDX_W-1:0]  slot_idx;
  logic              ack_sel;
  logic [DATA_W-1:0] slot_rdata;

  // Slot number is the page offset scaled down by the slot size; anything at or
  // beyond NUM_SLOTS (including nonzero upper offset bits) is unmapped.
  assign cpu_req    = cpu_we | cpu_re;
  assign slot_num   = cpu_addr[11:0] >> SLOT_SHIFT;
  assign slot_idx   = slot_num[IDX_W-1:0];
  assign is_ram     = cpu_addr[31:12] < MMIO_PAGE;
  assign is_slot    = (cpu_addr[31:12] == MMIO_PAGE) && (slot_num < NUM_SLOTS_L);
  assign ack_sel    = slv_ack[idx];
  assign slot_rdata = slv_rdata[int'(idx)*DATA_W +: DATA_W];

  assign ram_addr  = cpu_addr[RAM_AW+1:2];
  assign ram_wdata = cpu_wdata;

  always_comb begin
    ram_en    = 1'b0;
    ram_we    = '0;
    cpu_stall = 1'b0;
    cpu_rdata = '0;
    cpu_err   = 1'b0;
    case (state)
      S_IDLE: begin
        if (cpu_req) begin
          if (is_ram) begin
            ram_en = 1'b1;
            if (cpu_we) ram_we = cpu_be;
            else        cpu_stall = 1'b1;
          end else begin
            cpu_stall = 1'b1;
          end
        end
      end
      S_RAM_RD:   cpu_rdata = ram_rdata;
      S_SLV_WAIT: cpu_stall = 1'b1;
      S_RESP: begin
        cpu_rdata = rsp;
        cpu_err   = rsp_err;
      end
      default: ;
    endcase
  end

  // Error bookkeeping happens on the edge into RESP so the logged values are
  // already visible during the completion cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      slv_req   <= '0;
      slv_we    <= 1'b0;
      slv_addr  <= '0;
      slv_wdata <= '0;
      slv_be    <= '0;
      idx       <= '0;
      cnt       <= '0;
      rsp       <= '0;
      rsp_err   <= 1'b0;
      err_count <= '0;
      err_addr  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (cpu_req) begin
            if (is_ram) begin
              if (!cpu_we) state <= S_RAM_RD;
            end else if (is_slot) begin
              slv_req   <= NUM_SLOTS'(1) << slot_idx;
              slv_we    <= cpu_we;
              slv_addr  <= cpu_addr[SLOT_SHIFT-1:0];
              slv_wdata <= cpu_wdata;
              slv_be    <= cpu_be;
              idx       <= slot_idx;
              state     <= S_SLV_WAIT;
            end else begin
              rsp      <= '0;
              rsp_err  <= 1'b1;
              err_addr <= cpu_addr;
              if (err_count != 8'hFF) err_count <= err_count + 8'd1;
              state    <= S_RESP;
            end
          end
        end
        S_RAM_RD: state <= S_IDLE;
        S_SLV_WAIT: begin
          if (ack_sel) begin
            rsp     <= slot_rdata;
            rsp_err <= 1'b0;
            slv_req <= '0;
            state   <= S_RESP;
          end else if (cnt == CNT_LAST) begin
            rsp      <= '1;
            rsp_err  <= 1'b1;
            slv_req  <= '0;
            err_addr <= cpu_addr;
            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            state    <= S_RESP;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_RESP: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_slot_router.sv
// Scoreboard bench for mmio_slot_router: a reference model computes each access's
// expected response and timing from address arithmetic; a monitor compares on completion.
module tb_mmio_slot_router;

  localparam int          DATA_W    = 32;
  localparam int          RAM_AW    = 11;
  localparam int          NUM_SLOTS = 4;
  localparam int          TIMEOUT   = 15;
  localparam logic [31:0] MMIO_BASE = 32'hAAAAA000;

  logic                        clk = 1'b0;
  logic                        rst;
  logic [31:0]                 cpu_addr;
  logic [DATA_W-1:0]           cpu_wdata;
  logic [3:0]                  cpu_be;
  logic                        cpu_we, cpu_re;
  logic [DATA_W-1:0]           cpu_rdata;
  logic                        cpu_stall, cpu_err;
  logic                        ram_en;
  logic [3:0]                  ram_we;
  logic [RAM_AW-1:0]           ram_addr;
  logic [DATA_W-1:0]           ram_wdata;
  logic [DATA_W-1:0]           ram_rdata;
  logic [NUM_SLOTS-1:0]        slv_req;
  logic                        slv_we;
  logic [7:0]                  slv_addr;
  logic [DATA_W-1:0]           slv_wdata;
  logic [3:0]                  slv_be;
  logic [NUM_SLOTS*DATA_W-1:0] slv_rdata;
  logic [NUM_SLOTS-1:0]        slv_ack, resp_ack, manual_ack;
  logic [7:0]                  err_count;
  logic [31:0]                 err_addr;

  assign slv_ack = resp_ack | manual_ack;

  mmio_slot_router dut (
    .clk(clk), .rst(rst),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_be(cpu_be),
    .cpu_we(cpu_we), .cpu_re(cpu_re),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .cpu_err(cpu_err),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .slv_req(slv_req), .slv_we(slv_we), .slv_addr(slv_addr),
    .slv_wdata(slv_wdata), .slv_be(slv_be),
    .slv_rdata(slv_rdata), .slv_ack(slv_ack),
    .err_count(err_count), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  // Block RAM with one-cycle read latency.
  logic [31:0] ram_mem [0:2047];
  always @(posedge clk) begin
    if (ram_en) begin
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) ram_mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      ram_rdata <= ram_mem[ram_addr];
    end
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          req_cycles;
    logic [3:0]  req_vec;
    logic [7:0]  slv_off;
    logic        slv_we;
    logic        chk_ram;
    logic [3:0]  ram_we;
    logic [7:0]  ecount;
    logic [31:0] eaddr;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          passed = 0;
  logic [31:0] ref_mem [int];
  logic [7:0]  ref_ecount = 8'd0;
  logic [31:0] ref_eaddr  = 32'd0;
  int          resp_delay = 1000;
  logic [31:0] resp_data  = 32'd0;
  bit          mon_off    = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, req);
  endtask

  // Reference model: classifies the access by plain address arithmetic and
  // derives data, error and cycle counts, then drives the access to completion.
  task automatic applyStimulus(input logic [31:0] addr, input bit we, input bit re,
                               input logic [31:0] wdata, input logic [3:0] be,
                               input int delay, input logic [31:0] sdata);
    exp_t e;
    int   key, n;
    e = '{default: 0};
    if (addr < MMIO_BASE) begin
      key = int'((addr >> 2) % 2048);
      e.chk_ram = 1'b1;
      if (we) begin
        logic [31:0] w;
        w = ref_mem.exists(key) ? ref_mem[key] : 32'd0;
        for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = wdata[8*b +: 8];
        ref_mem[key] = w;
        e.lat = 1; e.ram_we = be;
      end else begin
        e.lat = 2; e.ram_we = 4'd0;
        e.rdata = ref_mem.exists(key) ? ref_mem[key] : 32'd0;
      end
    end else if (addr - MMIO_BASE < 32'(NUM_SLOTS * 256)) begin
      e.req_vec = 4'(1 << ((addr - MMIO_BASE) / 256));
      e.slv_off = 8'(addr % 256);
      e.slv_we  = we;
      if (delay < TIMEOUT) begin
        e.lat = delay + 3; e.req_cycles = delay + 1; e.rdata = sdata;
      end else begin
        e.lat = TIMEOUT + 2; e.req_cycles = TIMEOUT; e.rdata = 32'hFFFFFFFF; e.err = 1'b1;
      end
    end else begin
      e.lat = 2; e.rdata = 32'd0; e.err = 1'b1;
    end
    if (e.err) begin
      if (ref_ecount != 8'd255) ref_ecount++;
      ref_eaddr = addr;
    end
    e.ecount = ref_ecount;
    e.eaddr  = ref_eaddr;
    @(posedge clk); #1;
    resp_delay = delay; resp_data = sdata;
    exp_q.push_back(e);
    cpu_addr = addr; cpu_we = we; cpu_re = re; cpu_wdata = wdata; cpu_be = be;
    n = 0;
    do begin @(negedge clk); n++; end while (cpu_stall && n < 64);
    if (cpu_stall) checkOutput("completion_bound", 32'(n), 32'(e.lat));
  endtask

  task automatic goIdle();
    @(posedge clk); #1;
    cpu_we = 1'b0; cpu_re = 1'b0;
  endtask

  // Slot model: acks the requested slot a chosen number of cycles after req
  // rises, with random data and stray acks on slots that are not requested.
  initial begin
    int age = 0;
    resp_ack = '0; slv_rdata = '0;
    forever begin
      @(posedge clk); #1;
      for (int i = 0; i < NUM_SLOTS; i++) slv_rdata[i*32 +: 32] = $urandom;
      resp_ack = 4'($urandom_range(0, 15)) & ~slv_req;
      if (slv_req != '0) begin
        if (age == resp_delay) begin
          resp_ack = resp_ack | slv_req;
          for (int i = 0; i < NUM_SLOTS; i++) if (slv_req[i]) slv_rdata[i*32 +: 32] = resp_data;
        end
        age++;
      end else begin
        age = 0;
      end
    end
  end

  // Monitor: pops the scoreboard on every completion (request held, no stall).
  initial begin
    int         cyc = 0;
    int         reqcyc = 0;
    logic [3:0] prev_req = '0;
    exp_t       e;
    forever begin
      @(negedge clk);
      if (rst || mon_off) begin
        cyc = 0; reqcyc = 0; prev_req = slv_req;
      end else begin
        if (slv_req != '0) begin
          reqcyc++;
          if (prev_req == '0) begin
            if (exp_q.size() == 0) checkOutput("unexpected_req", 32'(slv_req), 32'd0);
            else begin
              checkOutput("slv_req", 32'(slv_req), 32'(exp_q[0].req_vec));
              checkOutput("slv_addr", 32'(slv_addr), 32'(exp_q[0].slv_off));
              checkOutput("slv_we", 32'(slv_we), 32'(exp_q[0].slv_we));
            end
          end
        end
        prev_req = slv_req;
        if (cpu_we | cpu_re) begin
          cyc++;
          if (cyc == 1 && exp_q.size() > 0 && exp_q[0].chk_ram) begin
            checkOutput("ram_en", 32'(ram_en), 32'd1);
            checkOutput("ram_we", 32'(ram_we), 32'(exp_q[0].ram_we));
          end
          if (!cpu_stall) begin
            if (exp_q.size() == 0) checkOutput("unexpected_completion", 32'(cyc), 32'd0);
            else begin
              e = exp_q.pop_front();
              checkOutput("latency", 32'(cyc), 32'(e.lat));
              checkOutput("req_cycles", 32'(reqcyc), 32'(e.req_cycles));
              checkOutput("cpu_err", 32'(cpu_err), 32'(e.err));
              if (cpu_re && !cpu_we || e.err || e.req_vec != '0)
                checkOutput("cpu_rdata", cpu_rdata, e.rdata);
              checkOutput("err_count", 32'(err_count), 32'(e.ecount));
              checkOutput("err_addr", err_addr, e.eaddr);
            end
            cyc = 0; reqcyc = 0;
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] a;
    int          kind;
    for (int i = 0; i < 2048; i++) ram_mem[i] = 32'd0;
    ram_rdata = '0; manual_ack = '0;
    cpu_addr = '0; cpu_wdata = '0; cpu_be = '0; cpu_we = 1'b0; cpu_re = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_slv_req", 32'(slv_req), 32'd0);
    checkOutput("reset_err_count", 32'(err_count), 32'd0);
    checkOutput("reset_err_addr", err_addr, 32'd0);
    checkOutput("reset_cpu_err", 32'(cpu_err), 32'd0);
    rst = 1'b0;

    $display("[TB] directed: RAM write/read, slot ack, timeout, collision");
    applyStimulus(32'h00000010, 1'b1, 1'b0, 32'hCAFEF00D, 4'hF, 0, 32'd0);
    applyStimulus(32'h00000010, 1'b0, 1'b1, 32'd0, 4'h0, 0, 32'd0);
    applyStimulus(32'hAAAAA104, 1'b0, 1'b1, 32'd0, 4'h0, 3, 32'h00000003);
    applyStimulus(32'hAAAAA000, 1'b0, 1'b1, 32'd0, 4'h0, 1000, 32'd0);
    applyStimulus(32'hAAAAA208, 1'b1, 1'b1, 32'h12345678, 4'h5, TIMEOUT - 1, 32'h0BADBEEF);
    applyStimulus(32'hAAAAA3FC, 1'b0, 1'b1, 32'd0, 4'h0, TIMEOUT, 32'h55AA55AA);
    goIdle();

    $display("[TB] directed: reset during slot wait");
    mon_off = 1'b1;
    resp_delay = 1000;
    @(posedge clk); #1;
    cpu_addr = MMIO_BASE; cpu_re = 1'b1; cpu_we = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("wait_slv_req", 32'(slv_req), 32'd1);
    rst = 1'b1; cpu_re = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    ref_ecount = 8'd0; ref_eaddr = 32'd0;
    checkOutput("rst_mid_slv_req", 32'(slv_req), 32'd0);
    checkOutput("rst_mid_err_count", 32'(err_count), 32'd0);
    checkOutput("rst_mid_err_addr", err_addr, 32'd0);
    repeat (2) @(posedge clk);
    #1 manual_ack = 4'b0001;
    @(posedge clk); #1 manual_ack = 4'b0000;
    @(negedge clk);
    checkOutput("late_ack_slv_req", 32'(slv_req), 32'd0);
    checkOutput("late_ack_cpu_err", 32'(cpu_err), 32'd0);
    checkOutput("late_ack_rdata", cpu_rdata, 32'd0);
    checkOutput("late_ack_stall", 32'(cpu_stall), 32'd0);
    mon_off = 1'b0;
    applyStimulus(32'h00000020, 1'b1, 1'b0, 32'h01020304, 4'hF, 0, 32'd0);
    goIdle();

    $display("[TB] randomized traffic");
    for (int t = 0; t < 150; t++) begin
      kind = $urandom_range(0, 4);
      case (kind)
        0: begin
          a = $urandom_range(0, 1) ? 32'($urandom_range(0, 127)) : $urandom % MMIO_BASE;
          applyStimulus(a, 1'b1, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)), 0, 32'd0);
        end
        1: begin
          a = $urandom_range(0, 1) ? 32'($urandom_range(0, 127)) : $urandom % MMIO_BASE;
          applyStimulus(a, 1'b0, 1'b1, $urandom, 4'd0, 0, 32'd0);
        end
        2, 3: begin
          a = MMIO_BASE + 32'($urandom_range(0, NUM_SLOTS - 1) * 256) + 32'($urandom_range(0, 255));
          if ($urandom_range(0, 1) == 1)
            applyStimulus(a, 1'b1, 1'b0, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 18), $urandom);
          else
            applyStimulus(a, 1'b0, 1'b1, 32'd0, 4'd0, $urandom_range(0, 18), $urandom);
        end
        default: begin
          if ($urandom_range(0, 1) == 1) a = MMIO_BASE + 32'($urandom_range(32'h400, 32'hFFF));
          else a = 32'hAAAAB000 + ($urandom % 32'h55555000);
          applyStimulus(a, 1'($urandom_range(0, 1)), 1'b1, $urandom, 4'hF, 0, 32'd0);
        end
      endcase
    end

    $display("[TB] unmapped reads to saturate the error counter");
    for (int t = 0; t < 256; t++)
      applyStimulus(32'hAAAAA800, 1'b0, 1'b1, 32'd0, 4'd0, 0, 32'd0);
    goIdle();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("sat_err_count", 32'(err_count), 32'd255);
    checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/mmio_slot_router.md
# mmio_slot_router

Data-side address router between the RISC-V core's load/store port and the shared data block RAM, with a parametrised number of memory-mapped peripheral slots (UART, display, LEDs, timers). Each slot has its own req/ack handshake, so slow peripherals stall the core instead of being sampled blindly. A per-transaction timeout ends hung slots with a bus error. An error counter records bad accesses for debug.

## Interface
- DATA_W, 32, data width; byte enables are DATA_W/8 wide.
- RAM_AW, 11, block-RAM word-address width.
- MMIO_PAGE, 20'hAAAAA, value of addr[31:12] selecting the MMIO page.
- NUM_SLOTS, 4, number of peripheral slots (1..16).
- SLOT_SHIFT, 8, log2 bytes per slot; SLOT_SHIFT + clog2(NUM_SLOTS) <= 12.
- TIMEOUT, 15, cycles a slot may hold off ack (1..255).
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, synchronous, active-high.
- cpu_addr  in  32  byte address, held stable while stalled.
- cpu_wdata  in  DATA_W  write data.
- cpu_be  in  DATA_W/8  byte enables for writes.
- cpu_we / cpu_re  in  1 each  write / read request; both high = write.
- cpu_rdata  out  DATA_W  read data, valid in the completion cycle only.
- cpu_stall  out  1  core must hold request while high.
- cpu_err  out  1  one-cycle pulse in completion cycle of a failed access.
- ram_en  out  1  RAM port enable.
- ram_we  out  DATA_W/8  RAM byte write enables.
- ram_addr  out  RAM_AW  equals cpu_addr[RAM_AW+1:2].
- ram_wdata  out  DATA_W  equals cpu_wdata.
- ram_rdata  in  DATA_W  RAM read data, 1-cycle latency.
- slv_req  out  NUM_SLOTS  one-hot request, registered.
- slv_we  out  1  registered write flag.
- slv_addr  out  SLOT_SHIFT  registered byte offset within slot.
- slv_wdata / slv_be  out  DATA_W, DATA_W/8  registered.
- slv_rdata  in  NUM_SLOTS*DATA_W  slot i read data in bits [i*DATA_W +: DATA_W].
- slv_ack  in  NUM_SLOTS  per-slot completion strobe.
- err_count  out  8  saturating count of failed accesses.
- err_addr  out  32  cpu_addr of most recent failed access.

## Operation
- Decode in IDLE on a request:
  - RAM: addr[31:12] < MMIO_PAGE.
  - Slot i: addr[31:12] == MMIO_PAGE, slot index addr[SLOT_SHIFT+clog2(N)-1:SLOT_SHIFT] == i < NUM_SLOTS, and the remaining bits [11:SLOT_SHIFT+clog2(N)] are zero.
  - Everything else is unmapped.
- States: IDLE, RAM_RD, SLV_WAIT, RESP.
- IDLE, RAM: combinational ram_en=1; ram_we=cpu_be on a write, 0 on a read.
  - Write completes this cycle: no stall, stay IDLE.
  - Read: stall=1, go to RAM_RD.
- RAM_RD: stall=0, cpu_rdata=ram_rdata, go to IDLE.
- IDLE, slot: stall=1; latch addr, wdata, be, we and the slot index; zero the timeout counter; go to SLV_WAIT.
- SLV_WAIT: slv_req[idx]=1 with latched fields; counter increments each cycle; stall=1.
  - slv_ack[idx]: capture slv_rdata slice into rsp register, drop req on that edge, go to RESP (ok).
  - Counter reaches TIMEOUT with no ack: drop req, rsp=all-ones, go to RESP (err).
  - Ack and timeout in the same cycle: ack wins.
  - Acks on other slots are ignored.
- IDLE, unmapped: stall=1, rsp=0, go to RESP (err).
- RESP: stall=0, cpu_rdata=rsp, cpu_err=err flag, go to IDLE.
  - On error: err_count += 1, saturating at 255; err_addr updated.
- Outputs outside the states above: cpu_rdata=0, cpu_err=0.
- Reset: state IDLE; slv_req, slv_we, cpu_err, err_count, err_addr, rsp and counter all 0.
- Reset mid-transaction: slv_req deasserts at that edge; a later ack is ignored.

## Timing
- RAM write: 1 cycle, no stall.
- RAM read: 2 cycles, one stall cycle.
- Slot access with ack k cycles after req rises (k>=0): k+3 cycles total.
  - Cycle 0: IDLE decode.
  - Cycle 1: req visible.
  - Cycle 1+k: ack.
  - Cycle 2+k: RESP.
- Timeout: req is high exactly TIMEOUT cycles; completion (RESP with error) follows in the next cycle.
- Unmapped access: 2 cycles, error pulse in cycle 1.
- A new request is accepted in the cycle after completion (back-to-back allowed).
- slv_* outputs change only on clock edges.

## Test plan
- RAM write, then read: write 0xCAFEF00D to 0x0000_0010 with be=4'b1111, then read → ram_we=4'hF in cycle 0; read returns 0xCAFEF00D with exactly 1 stall cycle; cpu_err=0.
- Slot ack: read 0xAAAAA104 with NUM_SLOTS=4; slot 1 acks 3 cycles after req, rdata=0x00000003 → slv_req=4'b0010, slv_addr=0x04; completion in cycle 5 with rdata 0x3, no error.
- Timeout: read 0xAAAAA000 with slot 0 never acking, TIMEOUT=15 → req high 15 cycles; RESP has rdata=0xFFFFFFFF, cpu_err=1, err_count=1, err_addr=0xAAAAA000.
- Unmapped and saturation: 256 reads to 0xAAAAA800 → each completes in 2 cycles with rdata=0 and cpu_err=1; err_count stops at 255.
- Ack/timeout collision: ack arrives in the same cycle as the timeout → ok response, err_count unchanged.
- Reset mid-wait: assert rst in cycle 3 of SLV_WAIT, then ack 2 cycles later → slv_req=0 after that edge; state stays IDLE; no cpu_err; all outputs at their reset values.
